fpnew_special_encoder: RTL and testbench



---
 rtl/fpnew_pkg.sv | 74 +++++++
 rtl/fpnew_skid_buffer.sv | 76 +++++++
 rtl/fpnew_special_encoder.sv | 58 +++++
 tb/tb_fpnew_special_encoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpnew_pkg.sv
// Shared floating-point definitions: format table and the special-value
// pattern generator that opgroups use to build canonical IEEE results.
package fpnew_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [2:0] {
    ZERO     = 3'd0,
    SUB_MIN  = 3'd1,
    NORM_MIN = 3'd2,
    NORM_MAX = 3'd3,
    ONE      = 3'd4,
    INF      = 3'd5,
    QNAN     = 3'd6,
    SNAN     = 3'd7
  } spec_class_e;

  function automatic int unsigned exp_bits(fp_format_e fmt);
    case (fmt)
      FP64:    return 11;
      FP16:    return 5;
      FP8:     return 5;
      FP16ALT: return 8;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned man_bits(fp_format_e fmt);
    case (fmt)
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 23;
    endcase
  endfunction

  function automatic int unsigned fp_width(fp_format_e fmt);
    return 1 + exp_bits(fmt) + man_bits(fmt);
  endfunction

  // Right-aligned {sign, exponent, mantissa} of the requested class; NaNs
  // are always emitted positive so they match the canonical RISC-V NaN.
  function automatic logic [63:0] spec_value(fp_format_e fmt, spec_class_e cls,
                                             logic sign);
    int unsigned eb = exp_bits(fmt);
    int unsigned mb = man_bits(fmt);
    logic [63:0] e_ones = (64'd1 << eb) - 64'd1;
    logic [63:0] m_ones = (64'd1 << mb) - 64'd1;
    logic [63:0] bias   = (64'd1 << (eb - 1)) - 64'd1;
    logic [63:0] e;
    logic [63:0] m;
    logic        s;
    s = sign;
    case (cls)
      ZERO:     begin e = '0;              m = '0;                   end
      SUB_MIN:  begin e = '0;              m = 64'd1;                end
      NORM_MIN: begin e = 64'd1;           m = '0;                   end
      NORM_MAX: begin e = e_ones - 64'd1;  m = m_ones;               end
      ONE:      begin e = bias;            m = '0;                   end
      INF:      begin e = e_ones;          m = '0;                   end
      SNAN:     begin s = 1'b0; e = e_ones; m = 64'd1;               end
      default:  begin s = 1'b0; e = e_ones; m = 64'd1 << (mb - 1);   end
    endcase
    return ({63'd0, s} << (eb + mb)) | (e << mb) | m;
  endfunction

endpackage

// File: rtl/fpnew_skid_buffer.sv
// Two-entry valid/ready buffer: a main register driving the outputs plus a
// skid register, so in_ready_o depends only on state (and flush).
module fpnew_skid_buffer #(
  parameter int unsigned DataWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DataWidth-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o
);

  logic                 main_valid_q, main_valid_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [DataWidth-1:0] main_data_q,  main_data_d;
  logic [DataWidth-1:0] skid_data_q,  skid_data_d;
  logic                 accept, transfer;

  assign in_ready_o = ~skid_valid_q & ~flush_i;
  assign accept     = in_valid_i & in_ready_o;
  assign transfer   = main_valid_q & out_ready_i;

  always_comb begin
    // NOTE: every next-state signal is given its hold value first so no
    // path through the block leaves it unassigned (which would infer a latch).
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (transfer) begin
        main_valid_d = skid_valid_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
      // in_ready_o is low while skid is full, so accept never meets a skid
      // promotion in the same cycle.
      if (accept) begin
        if (!main_valid_q || transfer) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data_i;
        end else begin
          skid_valid_d = 1'b1;
          skid_data_d  = in_data_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      // NOTE: data registers are reset too because the idle outputs must
      // read as zero; they are only two words, not a memory array.
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;

endmodule

// File: rtl/fpnew_special_encoder.sv
// Builds an IEEE pattern of a requested special class, optionally NaN-boxed
// to Width bits, and returns it through a 1-cycle skid-buffered handshake.
module fpnew_special_encoder
  import fpnew_pkg::*;
#(
  parameter fp_format_e  FpFormat = fp_format_e'(0),
  parameter int unsigned Width    = 32,
  parameter int unsigned TagWidth = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  spec_class_e         class_i,
  input  logic                sign_i,
  input  logic                box_i,
  input  logic [TagWidth-1:0] tag_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [Width-1:0]    result_o,
  output logic [TagWidth-1:0] tag_o
);

  localparam int unsigned FPW = fp_width(FpFormat);

  logic [FPW-1:0]   encoded;
  logic [Width-1:0] result_d;

  assign encoded = FPW'(spec_value(FpFormat, class_i, sign_i));

  if (Width < FPW) begin : gen_width_check
    $error("fpnew_special_encoder: Width must be >= format width");
  end

  if (Width > FPW) begin : gen_box
    assign result_d = {{(Width - FPW){box_i}}, encoded};
  end else begin : gen_no_box
    logic unused_box;
    assign unused_box = box_i;
    assign result_d   = encoded[Width-1:0];
  end

  fpnew_skid_buffer #(
    .DataWidth(Width + TagWidth)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  ({result_d, tag_i}),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o ({result_o, tag_o})
  );

endmodule

// File: tb/tb_fpnew_special_encoder.sv
// Directed and randomized checks of the special-value encoder in FP32 and
// boxed FP16 configurations driven from one shared request stream.
module tb_fpnew_special_encoder;
  import fpnew_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  spec_class_e cls = ZERO;
  logic        sign = 1'b0;
  logic        box = 1'b0;
  logic [3:0]  tag = '0;
  logic        out_ready = 1'b1;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [31:0] a_result, b_result;
  logic [3:0]  a_tag, b_tag;

  int checks = 0;
  int errors = 0;

  logic [35:0] qa[$];
  logic [35:0] qb[$];
  logic [35:0] pa, pb;
  bit          stall_prev = 1'b0;
  int          accepted = 0;

  spec_class_e d_cls[6]  = '{ZERO, INF, QNAN, NORM_MAX, SUB_MIN, ONE};
  logic        d_sign[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] d_exp[6]  = '{32'h80000000, 32'hFF800000, 32'h7FC00000,
                             32'h7F7FFFFF, 32'h00000001, 32'h3F800000};
  spec_class_e h_cls[3]  = '{QNAN, SNAN, NORM_MIN};
  logic        h_box[3]  = '{1'b1, 1'b0, 1'b1};
  logic [31:0] h_exp[3]  = '{32'hFFFF7E00, 32'h00007C01, 32'hFFFF8400};

  always #5 clk = ~clk;

  fpnew_special_encoder #(.FpFormat(FP32), .Width(32), .TagWidth(4)) u_dut_fp32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(a_in_ready), .class_i(cls), .sign_i(sign), .box_i(box),
    .tag_i(tag), .out_valid_o(a_out_valid), .out_ready_i(out_ready),
    .result_o(a_result), .tag_o(a_tag)
  );

  fpnew_special_encoder #(.FpFormat(FP16), .Width(32), .TagWidth(4)) u_dut_fp16 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(b_in_ready), .class_i(cls), .sign_i(sign), .box_i(box),
    .tag_i(tag), .out_valid_o(b_out_valid), .out_ready_i(out_ready),
    .result_o(b_result), .tag_o(b_tag)
  );

  function automatic longint unsigned pow2(int n);
    longint unsigned p = 1;
    return p << n;
  endfunction

  // Value of a class straight from the IEEE field definitions.
  function automatic logic [31:0] ref_value(int eb, int mb, spec_class_e c,
                                            logic s, logic b);
    longint unsigned emax = pow2(eb) - 1;
    longint unsigned e = 0, m = 0, sg = longint'(s), val;
    case (c)
      ZERO:     begin e = 0; m = 0; end
      SUB_MIN:  begin e = 0; m = 1; end
      NORM_MIN: begin e = 1; m = 0; end
      NORM_MAX: begin e = emax - 1; m = pow2(mb) - 1; end
      ONE:      begin e = pow2(eb - 1) - 1; m = 0; end
      INF:      begin e = emax; m = 0; end
      QNAN:     begin sg = 0; e = emax; m = pow2(mb - 1); end
      default:  begin sg = 0; e = emax; m = 1; end
    endcase
    val = sg * pow2(eb + mb) + e * pow2(mb) + m;
    if (b && (1 + eb + mb) < 32) val = val + (pow2(32) - pow2(1 + eb + mb));
    return 32'(val);
  endfunction

  task automatic check(input string name, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input spec_class_e c, input logic s,
                       input logic b, input logic [3:0] t, input logic ordy,
                       input logic fl = 1'b0, input logic r = 1'b0);
    @(negedge clk);
    in_valid = v; cls = c; sign = s; box = b; tag = t;
    out_ready = ordy; flush = fl; rst = r;
    #1;
  endtask

  // Called after drive(): checks the handshakes about to happen at the next edge.
  task automatic observe();
    logic [35:0] exp;
    check("rnd_ready_match", b_in_ready, a_in_ready);
    if (flush) check("rnd_flush_ready", a_in_ready, 0);
    if (stall_prev) begin
      check("rnd_hold_a", {a_out_valid, a_result, a_tag}, {1'b1, pa});
      check("rnd_hold_b", {b_out_valid, b_result, b_tag}, {1'b1, pb});
    end
    if (a_out_valid && out_ready) begin
      check("rnd_a_pending", qa.size() != 0, 1);
      if (qa.size() != 0) begin
        exp = qa.pop_front();
        check("rnd_a_out", {a_result, a_tag}, exp);
      end
    end
    if (b_out_valid && out_ready) begin
      check("rnd_b_pending", qb.size() != 0, 1);
      if (qb.size() != 0) begin
        exp = qb.pop_front();
        check("rnd_b_out", {b_result, b_tag}, exp);
      end
    end
    if (in_valid && a_in_ready) begin
      qa.push_back({ref_value(8, 23, cls, sign, 1'b0), tag});
      qb.push_back({ref_value(5, 10, cls, sign, box), tag});
      accepted++;
    end
    stall_prev = !flush && a_out_valid && !out_ready;
    pa = {a_result, a_tag};
    pb = {b_result, b_tag};
    if (flush) begin
      qa.delete();
      qb.delete();
    end
  endtask

  initial begin
    int cyc;
    logic v, s, b, ordy, fl;
    spec_class_e c;
    logic [3:0] t;

    // Reset state
    drive(0, ZERO, 0, 0, 0, 1, 0, 1);
    drive(0, ZERO, 0, 0, 0, 1, 0, 1);
    drive(0, ZERO, 0, 0, 0, 1);
    check("rst_valid", a_out_valid, 0);
    check("rst_ready", a_in_ready, 1);
    check("rst_result", a_result, 0);
    check("rst_tag", a_tag, 0);
    check("rst_result_b", b_result, 0);

    // FP32 back-to-back, 1-cycle latency
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) drive(1, d_cls[i], d_sign[i], 0, 4'(i + 1), 1);
      else       drive(0, ZERO, 0, 0, 0, 1);
      check("fp32_ready", a_in_ready, 1);
      if (i == 0) check("fp32_first_valid", a_out_valid, 0);
      else begin
        check("fp32_valid", a_out_valid, 1);
        check("fp32_result", a_result, d_exp[i-1]);
        check("fp32_tag", a_tag, i);
      end
    end

    // FP16 boxed into 32 bits (NaN sign requests ignored)
    for (int i = 0; i <= 3; i++) begin
      if (i < 3) drive(1, h_cls[i], 1'b1, h_box[i], 4'(i + 8), 1);
      else       drive(0, ZERO, 0, 0, 0, 1);
      if (i > 0) begin
        check("fp16_valid", b_out_valid, 1);
        check("fp16_result", b_result, h_exp[i-1]);
        check("fp16_tag", b_tag, i + 7);
      end
    end

    // Backpressure through the skid register
    drive(1, ONE, 0, 0, 4'd1, 0);
    check("bp_ready0", a_in_ready, 1);
    drive(1, ONE, 0, 0, 4'd2, 0);
    check("bp_hold1_tag", a_tag, 1);
    check("bp_ready1", a_in_ready, 1);
    drive(1, ONE, 0, 0, 4'd3, 0);
    check("bp_full_ready", a_in_ready, 0);
    check("bp_full_tag", a_tag, 1);
    drive(1, ONE, 0, 0, 4'd3, 0);
    check("bp_stall_valid", a_out_valid, 1);
    check("bp_stall_result", a_result, 32'h3F800000);
    drive(1, ONE, 0, 0, 4'd3, 1);
    check("bp_release_ready", a_in_ready, 0);
    check("bp_out_tag1", a_tag, 1);
    drive(1, ONE, 0, 0, 4'd3, 1);
    check("bp_ready_back", a_in_ready, 1);
    check("bp_out_tag2", a_tag, 2);
    drive(0, ZERO, 0, 0, 0, 1);
    check("bp_out_valid3", a_out_valid, 1);
    check("bp_out_tag3", a_tag, 3);
    drive(0, ZERO, 0, 0, 0, 1);
    check("bp_empty", a_out_valid, 0);

    // Flush with both entries full and a request in the flush cycle
    drive(1, INF, 0, 0, 4'd4, 0);
    drive(1, INF, 0, 0, 4'd5, 0);
    drive(1, INF, 0, 0, 4'd6, 0, 1);
    check("fl_ready_forced", a_in_ready, 0);
    drive(0, ZERO, 0, 0, 0, 1);
    check("fl_valid", a_out_valid, 0);
    check("fl_ready", a_in_ready, 1);
    drive(0, ZERO, 0, 0, 0, 1);
    check("fl_not_accepted", a_out_valid, 0);

    // Reset while stalled with two entries
    drive(1, NORM_MAX, 1, 0, 4'd7, 0);
    drive(1, NORM_MAX, 1, 0, 4'd8, 0);
    drive(0, ZERO, 0, 0, 0, 0, 0, 1);
    drive(0, ZERO, 0, 0, 0, 1);
    check("rst2_valid", a_out_valid, 0);
    check("rst2_result", a_result, 0);
    check("rst2_tag", a_tag, 0);
    check("rst2_ready", a_in_ready, 1);
    drive(1, SNAN, 1, 0, 4'd9, 1);
    check("rst2_lat_idle", a_out_valid, 0);
    drive(0, ZERO, 0, 0, 0, 1);
    check("rst2_lat_valid", a_out_valid, 1);
    check("rst2_lat_result", a_result, 32'h7F800001);
    check("rst2_lat_tag", a_tag, 9);
    drive(0, ZERO, 0, 0, 0, 1);

    // Random traffic against the reference model
    cyc = 0;
    while (accepted < 10000 && cyc < 40000) begin
      fl   = ($urandom_range(0, 199) == 0);
      v    = ($urandom_range(0, 3) != 0);
      c    = spec_class_e'($urandom_range(0, 7));
      s    = 1'($urandom);
      b    = 1'($urandom);
      t    = 4'($urandom);
      ordy = fl ? 1'b0 : ($urandom_range(0, 3) != 0);
      drive(v, c, s, b, t, ordy, fl);
      observe();
      cyc++;
    end
    check("rnd_budget", accepted >= 10000, 1);
    for (int i = 0; i < 4; i++) begin
      drive(0, ZERO, 0, 0, 0, 1);
      observe();
    end
    check("rnd_drained_a", qa.size(), 0);
    check("rnd_drained_b", qb.size(), 0);
    check("rnd_final_valid", a_out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
